// File: rtl/fifo_pkg.sv
// Shared types, reset defaults and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

    // Pointer width including the wrap bit used to tell full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Flag values while the FIFO is held in reset.
    localparam logic RST_FULL         = 1'b0;
    localparam logic RST_EMPTY        = 1'b1;
    localparam logic RST_ALMOST_FULL  = 1'b0;
    localparam logic RST_ALMOST_EMPTY = 1'b1;
    localparam logic RST_OVERFLOW     = 1'b0;
    localparam logic RST_UNDERFLOW    = 1'b0;

    // Status bundle presented by the FIFO.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Capture the write word; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and selectable registered or FWFT read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        w_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        r_en,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] AF_TH    = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_TH    = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      count_s;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;
    fifo_status_t          status_s;

    // Occupancy, flags and acceptance, all from the registered pointers.
    always_comb begin
        status_s              = '{RST_FULL, RST_EMPTY, RST_ALMOST_FULL,
                                  RST_ALMOST_EMPTY, RST_OVERFLOW, RST_UNDERFLOW};
        count_s               = wr_ptr_r - rd_ptr_r;
        status_s.full         = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                                (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
        status_s.empty        = (wr_ptr_r == rd_ptr_r);
        status_s.almost_full  = (count_s >= AF_TH);
        status_s.almost_empty = (count_s <= AE_TH);
        status_s.overflow     = overflow_r;
        status_s.underflow    = underflow_r;
        wr_acc_s              = w_en && !status_s.full;
        rd_acc_s              = r_en && !status_s.empty;
    end

    // Advance pointers on accepted operations; rejected requests leave state alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // One-cycle error pulses for requests refused on a full or empty FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= RST_OVERFLOW;
            underflow_r <= RST_UNDERFLOW;
        end else begin
            overflow_r  <= w_en && status_s.full;
            underflow_r <= r_en && status_s.empty;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (mem_rdata_s)
    );

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_WIDTH-1:0] data_out_r;

            // Registered read: head word captured on the accepting edge, held otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out_r <= {DATA_WIDTH{1'b0}};
                end else if (rd_acc_s) begin
                    data_out_r <= mem_rdata_s;
                end else begin
                    data_out_r <= data_out_r;
                end
            end

            assign data_out = data_out_r;
        end else begin : g_fwft_read
            // Head word shows through directly; zero while empty so reset reads as 0.
            assign data_out = status_s.empty ? {DATA_WIDTH{1'b0}} : mem_rdata_s;
        end
    endgenerate

    assign count        = count_s;
    assign full         = status_s.full;
    assign empty        = status_s.empty;
    assign almost_full  = status_s.almost_full;
    assign almost_empty = status_s.almost_empty;
    assign overflow     = status_s.overflow;
    assign underflow    = status_s.underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one registered-read and one FWFT instance share the
// same stimulus and are checked against a queue model of the FIFO.
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = 8'h00;

    logic [DW-1:0] dout0, doutf;
    logic          full0, empty0, af0, ae0, ovf0, unf0;
    logic          fullf, emptyf, aff, aef, ovff, unff;
    logic [4:0]    cnt0, cntf;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DW-1:0] q[$];
    logic [DW-1:0] last_rd = 8'h00;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0));

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dutf (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(doutf), .full(fullf), .empty(emptyf), .almost_full(aff),
        .almost_empty(aef), .count(cntf), .overflow(ovff), .underflow(unff));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, update the model, leave time at edge + 1.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        @(negedge clk);
        w_en = w; r_en = r; data_in = d;
        if (rst_n) begin
            exp_ovf = w && (q.size() == DEPTH);
            exp_unf = r && (q.size() == 0);
            if (r && q.size() > 0) last_rd = q.pop_front();
            if (w && !exp_ovf) q.push_back(d);
        end
        @(posedge clk);
        #1;
        w_en = 1'b0; r_en = 1'b0;
    endtask

    // Compare both instances against the model.
    task automatic check_model(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ".count"},  32'(cnt0),  32'(sz));
        chk({tag, ".countf"}, 32'(cntf),  32'(sz));
        chk({tag, ".full"},   32'(full0), 32'(sz == DEPTH));
        chk({tag, ".empty"},  32'(empty0), 32'(sz == 0));
        chk({tag, ".af"},     32'(af0),   32'(sz >= AF));
        chk({tag, ".ae"},     32'(ae0),   32'(sz <= AE));
        chk({tag, ".ovf"},    32'(ovf0),  32'(exp_ovf));
        chk({tag, ".unf"},    32'(unf0),  32'(exp_unf));
        chk({tag, ".flagsf"}, 32'({fullf, emptyf, aff, aef, ovff, unff}),
                              32'({full0 === 1'b1 ? 1'b1 : 1'b0, sz == 0, sz >= AF, sz <= AE, exp_ovf, exp_unf}) & 32'h1F
                              | 32'({sz == DEPTH, 5'b0}));
        chk({tag, ".dout0"},  32'(dout0), 32'(last_rd));
        if (sz > 0) chk({tag, ".doutf"}, 32'(doutf), 32'(q[0]));
    endtask

    typedef struct {
        logic          w;
        logic          r;
        logic [DW-1:0] din;
        int            cnt;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          ovf;
        logic          unf;
        logic [DW-1:0] d;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t v;
        int n;

        // Fill 0x00..0x0F, overflow attempt, drain 16, underflow, then w+r at empty.
        for (int i = 0; i < 16; i++) begin
            n = i + 1;
            v = '{1'b1, 1'b0, 8'(i), n, n == 16, 1'b0, n >= 14, n <= 2, 1'b0, 1'b0, 8'h00};
            tbl.push_back(v);
        end
        v = '{1'b1, 1'b0, 8'hEE, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl.push_back(v);
        for (int i = 0; i < 16; i++) begin
            n = 15 - i;
            v = '{1'b0, 1'b1, 8'h00, n, 1'b0, n == 0, n >= 14, n <= 2, 1'b0, 1'b0, 8'(i)};
            tbl.push_back(v);
        end
        v = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F};
        tbl.push_back(v);
        v = '{1'b1, 1'b1, 8'h77, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F};
        tbl.push_back(v);

        // Reset state.
        #2;
        chk("rst.count", 32'(cnt0), 32'd0);
        chk("rst.flags", 32'({full0, empty0, af0, ae0, ovf0, unf0}), 32'b010100);
        chk("rst.dout0", 32'(dout0), 32'd0);
        chk("rst.doutf", 32'(doutf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven fill/drain/error vectors.
        foreach (tbl[k]) begin
            step(tbl[k].w, tbl[k].r, tbl[k].din);
            chk($sformatf("vec%0d.count", k), 32'(cnt0), 32'(tbl[k].cnt));
            chk($sformatf("vec%0d.flags", k), 32'({full0, empty0, af0, ae0, ovf0, unf0}),
                32'({tbl[k].full, tbl[k].empty, tbl[k].af, tbl[k].ae, tbl[k].ovf, tbl[k].unf}));
            chk($sformatf("vec%0d.dout0", k), 32'(dout0), 32'(tbl[k].d));
        end
        check_model("after_tbl");

        // Bring count to 5, then 10 cycles of simultaneous write+read across the wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
        chk("sim.start", 32'(cnt0), 32'd5);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'h20 + 8'(i));
            chk("sim.count", 32'(cnt0), 32'd5);
            check_model("sim");
        end

        // Drain, then FWFT head visibility.
        while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
        check_model("drained");
        step(1'b1, 1'b0, 8'hA5);
        chk("fwft.head", 32'(doutf), 32'hA5);
        step(1'b1, 1'b0, 8'h5A);
        chk("fwft.still_head", 32'(doutf), 32'hA5);
        step(1'b0, 1'b1, 8'h00);
        chk("fwft.next", 32'(doutf), 32'h5A);
        chk("fwft.reg_read", 32'(dout0), 32'hA5);
        step(1'b0, 1'b1, 8'h00);
        chk("fwft.empty", 32'(emptyf), 32'd1);
        check_model("fwft");

        // Reset mid-stream at count 9.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
        chk("pre_rst.count", 32'(cnt0), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.count", 32'(cnt0), 32'd0);
        chk("mrst.flags", 32'({full0, empty0, af0, ae0, ovf0, unf0}), 32'b010100);
        chk("mrst.dout0", 32'(dout0), 32'd0);
        q.delete();
        last_rd = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
        step(1'b1, 1'b0, 8'hFF);
        chk("rst_hold.count", 32'(cnt0), 32'd0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h3C);
        chk("post_rst.head", 32'(doutf), 32'h3C);
        step(1'b0, 1'b1, 8'h00);
        chk("post_rst.first", 32'(dout0), 32'h3C);
        check_model("post_rst");

        // Random traffic with alternating write-heavy / read-heavy phases.
        for (int c = 0; c < 2000; c++) begin
            int pw;
            pw = ((c / 150) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), 8'($urandom));
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
